// File: rtl/syn_wm8731_pkg.sv
// Shared definitions for the WM8731 control-port responder: FSM states,
// register map, power-on defaults and the codec device address.
package syn_wm8731_pkg;

   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_DADDR  = 4'd1,
      ST_DACK   = 4'd2,
      ST_BYTE1  = 4'd3,
      ST_ACK1   = 4'd4,
      ST_BYTE2  = 4'd5,
      ST_ACK2   = 4'd6,
      ST_NACK   = 4'd7,
      ST_IGNORE = 4'd8
   } i2c_state_e;

   localparam logic [6:0] REG_LINVOL   = 7'h00;
   localparam logic [6:0] REG_RINVOL   = 7'h01;
   localparam logic [6:0] REG_LHPOUT   = 7'h02;
   localparam logic [6:0] REG_RHPOUT   = 7'h03;
   localparam logic [6:0] REG_APANA    = 7'h04;
   localparam logic [6:0] REG_DPATH    = 7'h05;
   localparam logic [6:0] REG_PWR      = 7'h06;
   localparam logic [6:0] REG_DAIF     = 7'h07;
   localparam logic [6:0] REG_SAMPLING = 7'h08;
   localparam logic [6:0] REG_ACTIVE   = 7'h09;
   localparam logic [6:0] REG_RESET    = 7'h0F;

   localparam logic [6:0] WM8731_DEV_ADDR = 7'h1A;
   localparam int         WM8731_NUM_REGS = 10;

   // Element i is the reset value of register Ri.
   localparam logic [9:0][8:0] REG_DEFAULTS = {
      9'h000, 9'h000, 9'h00A, 9'h09F, 9'h008,
      9'h00A, 9'h079, 9'h079, 9'h097, 9'h097
   };

   function automatic logic [8:0] reg_default(input logic [3:0] idx);
      logic [8:0] val;
      if (idx < 4'd10) begin
         val = REG_DEFAULTS[idx];
      end else begin
         val = 9'h000;
      end
      return val;
   endfunction

endpackage

// File: rtl/syn_i2c_bus_mon.sv
// I2C bus monitor: synchronises scl/sda, detects START/STOP and scl edges,
// and presents the sda level seen at each scl edge. All strobes are registered.
module syn_i2c_bus_mon (
   input  logic clk,
   input  logic rst_n,
   input  logic scl,
   input  logic sda,
   output logic start,
   output logic stop,
   output logic scl_rise,
   output logic scl_fall,
   output logic sda_bit
);

   logic [1:0] scl_sync_r;
   logic [1:0] sda_sync_r;
   logic       scl_prev_r;
   logic       sda_prev_r;
   logic       start_r;
   logic       stop_r;
   logic       scl_rise_r;
   logic       scl_fall_r;
   logic       sda_bit_r;

   // Synchroniser, edge-detect stage and registered bus-condition strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_sync_r <= 2'b11;
         sda_sync_r <= 2'b11;
         scl_prev_r <= 1'b1;
         sda_prev_r <= 1'b1;
         start_r    <= 1'b0;
         stop_r     <= 1'b0;
         scl_rise_r <= 1'b0;
         scl_fall_r <= 1'b0;
         sda_bit_r  <= 1'b1;
      end else begin
         scl_sync_r <= {scl_sync_r[0], scl};
         sda_sync_r <= {sda_sync_r[0], sda};
         scl_prev_r <= scl_sync_r[1];
         sda_prev_r <= sda_sync_r[1];
         start_r    <= scl_sync_r[1] & scl_prev_r & sda_prev_r & ~sda_sync_r[1];
         stop_r     <= scl_sync_r[1] & scl_prev_r & ~sda_prev_r & sda_sync_r[1];
         scl_rise_r <= scl_sync_r[1] & ~scl_prev_r;
         scl_fall_r <= ~scl_sync_r[1] & scl_prev_r;
         sda_bit_r  <= sda_sync_r[1];
      end
   end

   assign start    = start_r;
   assign stop     = stop_r;
   assign scl_rise = scl_rise_r;
   assign scl_fall = scl_fall_r;
   assign sda_bit  = sda_bit_r;

endmodule

// File: rtl/syn_wm8731_i2c_slave.sv
// WM8731 control-port responder: ACKs the codec address, captures 16-bit
// register writes into a 9-bit register file with a registered read port.
module syn_wm8731_i2c_slave
   import syn_wm8731_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR = WM8731_DEV_ADDR,
   parameter int         NUM_REGS = WM8731_NUM_REGS,
   parameter logic [6:0] RST_REG  = REG_RESET
) (
   input  logic       clk_ir,
   input  logic       rst_il,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       sda_oe_o,
   output logic       reg_wr_o,
   output logic [6:0] reg_addr_o,
   output logic [8:0] reg_data_o,
   output logic       addr_err_o,
   output logic       busy_o,
   input  logic [3:0] rd_addr_i,
   output logic [8:0] rd_data_o
);

   localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   logic       start_s, stop_s, scl_rise_s, scl_fall_s, sda_bit_s;
   i2c_state_e state_r, state_next_s;
   logic       sda_oe_r, sda_oe_next_s;
   logic       busy_r, busy_next_s;
   logic       cnt_clr_s, latch_byte1_s, commit_s, shift_en_s;
   logic [3:0] bit_cnt_r;
   logic [7:0] shift_r;
   logic [7:0] byte1_r;
   logic [6:0] commit_addr_s;
   logic [8:0] commit_data_s;
   logic       reg_wr_r, addr_err_r;
   logic [6:0] reg_addr_r;
   logic [8:0] reg_data_r;
   logic [8:0] rd_data_r;
   logic [8:0] regs_r [NUM_REGS];

   syn_i2c_bus_mon u_bus_mon (
      .clk      (clk_ir),
      .rst_n    (rst_il),
      .scl      (scl_i),
      .sda      (sda_i),
      .start    (start_s),
      .stop     (stop_s),
      .scl_rise (scl_rise_s),
      .scl_fall (scl_fall_s),
      .sda_bit  (sda_bit_s)
   );

   assign commit_addr_s = byte1_r[7:1];
   assign commit_data_s = {byte1_r[0], shift_r};
   assign shift_en_s    = scl_rise_s && (bit_cnt_r < 4'd8) &&
                          ((state_r == ST_DADDR) || (state_r == ST_BYTE1) ||
                           (state_r == ST_BYTE2) || (state_r == ST_NACK));

   // Next-state logic; ACK slots open and close on scl falling edges.
   always_comb begin
      state_next_s  = state_r;
      sda_oe_next_s = sda_oe_r;
      busy_next_s   = busy_r;
      cnt_clr_s     = 1'b0;
      latch_byte1_s = 1'b0;
      commit_s      = 1'b0;
      if (start_s) begin
         state_next_s  = ST_DADDR;
         sda_oe_next_s = 1'b0;
         busy_next_s   = 1'b1;
         cnt_clr_s     = 1'b1;
      end else if (stop_s) begin
         state_next_s  = ST_IDLE;
         sda_oe_next_s = 1'b0;
         busy_next_s   = 1'b0;
         cnt_clr_s     = 1'b1;
      end else if (scl_fall_s) begin
         case (state_r)
            ST_DADDR: begin
               if (bit_cnt_r == 4'd8) begin
                  if ((shift_r[7:1] == DEV_ADDR) && !shift_r[0]) begin
                     state_next_s  = ST_DACK;
                     sda_oe_next_s = 1'b1;
                  end else begin
                     state_next_s = ST_IGNORE;
                  end
               end else begin
                  state_next_s = ST_DADDR;
               end
            end
            ST_DACK: begin
               state_next_s  = ST_BYTE1;
               sda_oe_next_s = 1'b0;
               cnt_clr_s     = 1'b1;
            end
            ST_BYTE1: begin
               if (bit_cnt_r == 4'd8) begin
                  state_next_s  = ST_ACK1;
                  sda_oe_next_s = 1'b1;
                  latch_byte1_s = 1'b1;
               end else begin
                  state_next_s = ST_BYTE1;
               end
            end
            ST_ACK1: begin
               state_next_s  = ST_BYTE2;
               sda_oe_next_s = 1'b0;
               cnt_clr_s     = 1'b1;
            end
            ST_BYTE2: begin
               if (bit_cnt_r == 4'd8) begin
                  state_next_s  = ST_ACK2;
                  sda_oe_next_s = 1'b1;
               end else begin
                  state_next_s = ST_BYTE2;
               end
            end
            ST_ACK2: begin
               state_next_s  = ST_NACK;
               sda_oe_next_s = 1'b0;
               cnt_clr_s     = 1'b1;
               commit_s      = 1'b1;
            end
            ST_NACK: begin
               if (bit_cnt_r == 4'd8) begin
                  state_next_s = ST_IGNORE;
               end else begin
                  state_next_s = ST_NACK;
               end
            end
            default: begin
               state_next_s = state_r;
            end
         endcase
      end else begin
         state_next_s = state_r;
      end
   end

   // FSM state and bus-facing control registers.
   always_ff @(posedge clk_ir or negedge rst_il) begin
      if (!rst_il) begin
         state_r  <= ST_IDLE;
         sda_oe_r <= 1'b0;
         busy_r   <= 1'b0;
      end else begin
         state_r  <= state_next_s;
         sda_oe_r <= sda_oe_next_s;
         busy_r   <= busy_next_s;
      end
   end

   // Bit counter and MSB-first shift register.
   always_ff @(posedge clk_ir or negedge rst_il) begin
      if (!rst_il) begin
         bit_cnt_r <= 4'd0;
         shift_r   <= 8'h00;
         byte1_r   <= 8'h00;
      end else begin
         if (cnt_clr_s) begin
            bit_cnt_r <= 4'd0;
         end else if (shift_en_s) begin
            bit_cnt_r <= bit_cnt_r + 4'd1;
            shift_r   <= {shift_r[6:0], sda_bit_s};
         end
         if (latch_byte1_s) begin
            byte1_r <= shift_r;
         end
      end
   end

   // Commit, register file and read port; a same-cycle read sees the old value.
   always_ff @(posedge clk_ir or negedge rst_il) begin
      if (!rst_il) begin
         reg_wr_r   <= 1'b0;
         addr_err_r <= 1'b0;
         reg_addr_r <= 7'h00;
         reg_data_r <= 9'h000;
         rd_data_r  <= 9'h000;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_r[i] <= reg_default(4'(i));
         end
      end else begin
         reg_wr_r   <= 1'b0;
         addr_err_r <= 1'b0;
         if (int'(rd_addr_i) < NUM_REGS) begin
            rd_data_r <= regs_r[rd_addr_i[IDX_W-1:0]];
         end else begin
            rd_data_r <= 9'h000;
         end
         if (commit_s) begin
            reg_addr_r <= commit_addr_s;
            reg_data_r <= commit_data_s;
            if (int'(commit_addr_s) < NUM_REGS) begin
               regs_r[commit_addr_s[IDX_W-1:0]] <= commit_data_s;
               reg_wr_r <= 1'b1;
            end else if (commit_addr_s == RST_REG) begin
               for (int i = 0; i < NUM_REGS; i++) begin
                  regs_r[i] <= reg_default(4'(i));
               end
               reg_wr_r <= 1'b1;
            end else begin
               addr_err_r <= 1'b1;
            end
         end
      end
   end

   assign sda_oe_o   = sda_oe_r;
   assign busy_o     = busy_r;
   assign reg_wr_o   = reg_wr_r;
   assign addr_err_o = addr_err_r;
   assign reg_addr_o = reg_addr_r;
   assign reg_data_o = reg_data_r;
   assign rd_data_o  = rd_data_r;

endmodule

// File: tb/tb_syn_wm8731_i2c_slave.sv
// Self-checking bench: a bit-banged I2C master drives directed and random
// write transactions against a behavioural register-map model.
`timescale 1ns/1ps
module tb_syn_wm8731_i2c_slave;

   localparam int H = 5;
   localparam logic [8:0] DEF [10] = '{9'h097, 9'h097, 9'h079, 9'h079, 9'h00A,
                                      9'h008, 9'h09F, 9'h00A, 9'h000, 9'h000};

   logic       clk, rst_il, scl, sda_m, sda_bus;
   logic       sda_oe_o, reg_wr_o, addr_err_o, busy_o;
   logic [6:0] reg_addr_o;
   logic [8:0] reg_data_o, rd_data_o;
   logic [3:0] rd_addr_i;

   int n_checks = 0;
   int n_errors = 0;
   int wr_cnt = 0, err_cnt = 0, oe_cnt = 0;
   int exp_wr = 0, exp_err = 0;
   logic [8:0] mreg [10];

   assign sda_bus = sda_m & ~sda_oe_o;

   syn_wm8731_i2c_slave dut (
      .clk_ir     (clk),
      .rst_il     (rst_il),
      .scl_i      (scl),
      .sda_i      (sda_bus),
      .sda_oe_o   (sda_oe_o),
      .reg_wr_o   (reg_wr_o),
      .reg_addr_o (reg_addr_o),
      .reg_data_o (reg_data_o),
      .addr_err_o (addr_err_o),
      .busy_o     (busy_o),
      .rd_addr_i  (rd_addr_i),
      .rd_data_o  (rd_data_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse and open-drain activity counters, sampled away from the active edge.
   always @(negedge clk) begin
      if (reg_wr_o) wr_cnt++;
      if (addr_err_o) err_cnt++;
      if (sda_oe_o) oe_cnt++;
   end

   initial begin
      #800000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; tick(H);
      scl = 1'b1;   tick(H);
      sda_m = 1'b0; tick(H);
      scl = 1'b0;   tick(2);
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; tick(H);
      scl = 1'b1;   tick(H);
      sda_m = 1'b1; tick(H);
   endtask

   task automatic send_bits(input logic [7:0] b, input int nbits);
      for (int i = 7; i > 7 - nbits; i--) begin
         sda_m = b[i]; tick(H);
         scl = 1'b1;   tick(H);
         scl = 1'b0;   tick(2);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, output logic acked);
      send_bits(b, 8);
      sda_m = 1'b1; tick(H);
      scl = 1'b1;   tick(H / 2);
      acked = ~sda_bus;
      tick(H - H / 2);
      scl = 1'b0;   tick(2);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 10; i++) mreg[i] = DEF[i];
   endtask

   task automatic model_commit(input logic [6:0] ra, input logic [8:0] d);
      if (ra < 7'd10) begin
         mreg[ra[3:0]] = d;
         exp_wr++;
      end else if (ra == 7'h0F) begin
         model_reset();
         exp_wr++;
      end else begin
         exp_err++;
      end
   endtask

   task automatic read_all();
      logic [8:0] exp;
      for (int i = 0; i < 16; i++) begin
         rd_addr_i = 4'(i);
         @(posedge clk);
         @(negedge clk);
         exp = (i < 10) ? mreg[i] : 9'h000;
         chk($sformatf("rd_r%0d", i), 32'(rd_data_o), 32'(exp));
      end
   endtask

   task automatic wm_write(input logic [6:0] dev, input logic rw, input logic [6:0] ra,
                           input logic [8:0] d, input int n, input bit do_stop);
      logic [7:0] bytes [4];
      logic       a, match;
      int         acks, exp_acks, oe0;
      bytes[0] = {dev, rw};
      bytes[1] = {ra, d[8]};
      bytes[2] = d[7:0];
      bytes[3] = 8'($urandom);
      match    = (dev == 7'h1A) && !rw;
      exp_acks = match ? ((n < 3) ? n : 3) : 0;
      oe0      = oe_cnt;
      acks     = 0;
      i2c_start();
      chk("busy_start", 32'(busy_o), 32'd1);
      for (int k = 0; k < n; k++) begin
         send_byte(bytes[k], a);
         if (a) acks++;
      end
      if (do_stop) i2c_stop();
      tick(4);
      if (match && n >= 3) model_commit(ra, d);
      chk("acks", 32'(acks), 32'(exp_acks));
      if (exp_acks == 0) chk("oe_quiet", 32'(oe_cnt), 32'(oe0));
      chk("wr_cnt", 32'(wr_cnt), 32'(exp_wr));
      chk("err_cnt", 32'(err_cnt), 32'(exp_err));
      if (match && n >= 3) begin
         chk("reg_addr", 32'(reg_addr_o), 32'(ra));
         chk("reg_data", 32'(reg_data_o), 32'(d));
      end
      if (do_stop) chk("busy_stop", 32'(busy_o), 32'd0);
   endtask

   initial begin
      logic a;
      rst_il = 1'b0; scl = 1'b1; sda_m = 1'b1; rd_addr_i = 4'd0;
      model_reset();
      tick(3);
      chk("rst_oe", 32'(sda_oe_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_wr", 32'(reg_wr_o), 32'd0);
      chk("rst_err", 32'(addr_err_o), 32'd0);
      chk("rst_addr", 32'(reg_addr_o), 32'd0);
      chk("rst_data", 32'(reg_data_o), 32'd0);
      chk("rst_rd", 32'(rd_data_o), 32'd0);
      rst_il = 1'b1;
      tick(3);
      read_all();

      wm_write(7'h1A, 1'b0, 7'h04, 9'h012, 3, 1'b1);
      read_all();
      wm_write(7'h1B, 1'b0, 7'h02, 9'h155, 3, 1'b1);
      wm_write(7'h1A, 1'b1, 7'h02, 9'h155, 3, 1'b1);
      read_all();
      wm_write(7'h1A, 1'b0, 7'h06, 9'h000, 3, 1'b1);
      wm_write(7'h1A, 1'b0, 7'h0F, 9'h000, 3, 1'b1);
      read_all();
      wm_write(7'h1A, 1'b0, 7'h05, 9'h1FF, 2, 1'b1);
      wm_write(7'h1A, 1'b0, 7'h07, 9'h0AA, 2, 1'b0);
      wm_write(7'h1A, 1'b0, 7'h09, 9'h001, 3, 1'b1);
      wm_write(7'h1A, 1'b0, 7'h0C, 9'h123, 4, 1'b1);
      read_all();

      for (int it = 0; it < 20; it++) begin
         logic [6:0] dev, ra;
         logic       rw;
         int         n;
         dev = ($urandom_range(0, 7) == 0) ? 7'h1B : 7'h1A;
         rw  = ($urandom_range(0, 9) == 0);
         ra  = 7'($urandom_range(0, 15));
         n   = ($urandom_range(0, 5) == 0) ? 2 : int'($urandom_range(3, 4));
         wm_write(dev, rw, ra, 9'($urandom), n, 1'b1);
         if (it % 7 == 6) read_all();
      end
      read_all();

      // Reset in the middle of the data byte.
      i2c_start();
      send_byte({7'h1A, 1'b0}, a);
      send_byte({7'h03, 1'b1}, a);
      send_bits(8'h5A, 4);
      rst_il = 1'b0;
      #1;
      chk("mid_rst_oe", 32'(sda_oe_o), 32'd0);
      chk("mid_rst_busy", 32'(busy_o), 32'd0);
      chk("mid_rst_addr", 32'(reg_addr_o), 32'd0);
      model_reset();
      tick(3);
      rst_il = 1'b1;
      tick(2);
      i2c_stop();
      tick(4);
      wr_cnt = 0; err_cnt = 0; exp_wr = 0; exp_err = 0;
      read_all();
      wm_write(7'h1A, 1'b0, 7'h03, 9'h1C3, 3, 1'b1);
      read_all();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/syn_wm8731_i2c_slave.md
Name: syn_wm8731_i2c_slave

Overview:
Synthesizable I2C responder modelling the WM8731 control port: the far end of the codec's scl/sda bus.
- Oversamples scl/sda on the system clock and decodes START/STOP.
- Acknowledges the codec device address.
- Captures the codec's 16-bit register writes into a 9-bit-wide register file.
- Used for FPGA loopback self-test of the I2C master and as a scoreboard-visible register model in bench builds.

Parameters:
DEV_ADDR, 7'h1A, 7-bit device address this block acknowledges (WM8731 with CSB low).
NUM_REGS, 10, number of implemented registers, R0..R9.
RST_REG, 7'h0F, register address whose write restores all defaults.

Ports:
clk_ir  input  1  system clock
rst_il  input  1  asynchronous active-low reset
scl_i  input  1  I2C clock from bus, asynchronous to clk_ir
sda_i  input  1  I2C data sampled from bus, asynchronous to clk_ir
sda_oe_o  output  1  1 = pull sda low (open-drain); 0 = release
reg_wr_o  output  1  one-cycle pulse on committed register write
reg_addr_o  output  7  register address of the last write attempt
reg_data_o  output  9  data of the last write attempt
addr_err_o  output  1  one-cycle pulse when a write targets an unimplemented address
busy_o  output  1  high from START to STOP
rd_addr_i  input  4  register file read index
rd_data_o  output  9  registered read data, 1-cycle latency; 0 for index >= NUM_REGS

Behaviour:
- Reset values: sda_oe_o=0, reg_wr_o=0, addr_err_o=0, busy_o=0, reg_addr_o=0, reg_data_o=0, rd_data_o=0, FSM=IDLE. Register file loads defaults R0..R9 = 0x097, 0x097, 0x079, 0x079, 0x00A, 0x008, 0x09F, 0x00A, 0x000, 0x000.
- Input conditioning:
  - scl_i and sda_i each pass through a 2-flop synchronizer, then a 1-flop edge-detect stage.
  - Each scl high and low phase must last at least 4 clk_ir cycles.
- Bus conditions:
  - START = sda falling while scl high.
  - STOP = sda rising while scl high.
  - Data bits are sampled on the scl rising edge, MSB first.
- FSM states: IDLE, DADDR, DACK, BYTE1, ACK1, BYTE2, ACK2, NACK, IGNORE.
  - START from any state: go to DADDR, clear the bit counter, busy_o=1. This covers repeated START.
  - STOP from any state: go to IDLE, busy_o=0, sda_oe_o=0. A partially received transaction is discarded with no write.
  - DADDR: after 8 bits, if bits[7:1]==DEV_ADDR and R/W==0, go to DACK. Otherwise (address mismatch, or read request, since the codec is write-only) go to IGNORE and never drive sda.
  - ACK slots (DACK, ACK1, ACK2):
    - sda_oe_o rises at the first scl falling edge after the 8th bit.
    - It falls at the next scl falling edge.
    - The state then advances DACK->BYTE1, ACK1->BYTE2, ACK2->NACK.
  - BYTE1 = {reg_addr[6:0], data[8]}; BYTE2 = data[7:0].
  - Commit: on the scl falling edge that ends ACK2, reg_addr_o and reg_data_o update. Then exactly one of these applies:
    - addr < NUM_REGS: write the register file and pulse reg_wr_o.
    - addr == RST_REG: reload all defaults and pulse reg_wr_o.
    - Otherwise: pulse addr_err_o and leave the file unchanged.
    - Out-of-range bytes are still ACKed.
  - NACK: any further byte after ACK2 is received but not acknowledged (sda released). The FSM then enters IGNORE until STOP or START.
- Read port versus commit: if rd_addr_i matches the address committed in the same cycle, rd_data_o returns the old value that cycle and the new value on the following cycle.
- Reset asserted mid-transaction: all state clears immediately, sda is released, and register defaults are restored. After reset deasserts, the block waits for a fresh START.

Decomposition:
- Shared package syn_wm8731_pkg holds:
  - FSM state enum.
  - WM8731 register address localparams (R0 LINVOL .. R9 ACTIVE, R15 RESET).
  - Default value array.
  - Device address constant.
- One sub-module, syn_i2c_bus_mon: synchronizers, edge detect, START/STOP detect and per-bit sample strobes. It is reusable by the TB_I2C monitor.

Test Plan:
- Write DEV_ADDR=0x1A/W, bytes 0x08,0x12 (R4=0x012) -> 3 ACKs; reg_wr_o one pulse; reg_addr_o=0x04, reg_data_o=0x012; rd_addr_i=4 returns 0x012.
- Address 0x1B/W -> no ACK, sda_oe_o stays 0 for the whole transaction; register file unchanged.
- Address 0x1A/R -> NACK; no writes; busy_o drops at STOP.
- Write R6=0x000, then write reg 0x0F data 0x000 -> after second commit R6 reads 0x09F and all defaults are restored.
- STOP after BYTE1 -> no reg_wr_o; then repeated START + full write to R9=0x001 -> R9 reads 0x001.
- Write reg 0x0C -> all 3 bytes ACKed, addr_err_o pulses, no reg_wr_o. Then a 4th byte after ACK2 -> NACKed.
- Assert rst_il during BYTE2 -> sda_oe_o=0 immediately; defaults restored; next full transaction succeeds.
